id_ex_operand_stage: RTL and testbench
======================================

Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register plus execute-operand selection, directly upstream of the ALU.
- Captures the decode bundle each cycle and resolves RAW hazards by forwarding from MEM and WB.
- Detects load-use hazards and inserts bubbles.
- Drives the ALU `a`, `b` and `f` inputs, plus the control/data bundle for EX/MEM.

Parameters:
- XLEN, 32, datapath width.
- RA_W, 5, register-address width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- id_valid  in  1  decode slot holds a real instruction
- id_pc  in  XLEN  instruction PC
- id_rs1, id_rs2  in  RA_W  source register indices
- id_use_rs1, id_use_rs2  in  1  instruction reads rs1/rs2
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data
- id_imm  in  XLEN  sign-extended immediate
- id_alu_src  in  1  0: b=rs2, 1: b=imm
- id_alu_f  in  3  ALU function code (000 add … 111 srl)
- id_rd  in  RA_W  destination register
- id_reg_write, id_mem_read, id_mem_write  in  1  control bits
- stall_in  in  1  downstream hold; EX must not advance
- flush  in  1  branch redirect; kill the instruction entering EX
- mem_reg_write  in  1  MEM-stage write enable
- mem_rd  in  RA_W  MEM-stage destination
- mem_result  in  XLEN  MEM-stage result
- wb_reg_write  in  1  WB-stage write enable
- wb_rd  in  RA_W  WB-stage destination
- wb_result  in  XLEN  WB-stage result
- alu_a, alu_b  out  XLEN  ALU operands
- alu_f  out  3  ALU function
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write  out  1  EX bundle
- ex_rd  out  RA_W  EX destination
- ex_pc  out  XLEN  EX PC
- ex_store_data  out  XLEN  forwarded rs2 value
- load_use_stall  out  1  freeze PC and IF/ID this cycle
- bubble_count  out  16  saturating count of inserted bubbles

Behaviour:
- Reset (asynchronous, active-high):
  - all EX registers clear to 0; ex_valid=0; bubble_count=0.
  - Consequently alu_a=alu_b=0, alu_f=000, load_use_stall=0.
- load_use_stall (combinational):
  - = ex_valid & ex_mem_read & ex_rd≠0 & id_valid & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
  - Forced to 0 while stall_in=1.
- Register update at posedge clk, priority order:
  1. flush: ex_valid and all ex_* control bits←0; data fields don't-care.
  2. stall_in: hold all fields, except stored rs1/rs2 data are overwritten with the current forwarded operand values, so a result retiring from MEM/WB during the hold is not lost.
  3. load_use_stall: insert a bubble (valid/control bits←0); bubble_count increments, saturating at 0xFFFF.
  4. Otherwise: capture the full id_* bundle. ex_valid←id_valid; control bits are ANDed with id_valid.
- Forwarding (combinational, from the registered stage):
  - Per source: if mem_reg_write & mem_rd≠0 & mem_rd==ex_rsN → mem_result.
  - Else if wb_reg_write & wb_rd≠0 & wb_rd==ex_rsN → wb_result.
  - Else stored data.
  - MEM has priority over WB; x0 is never forwarded.
- Operand outputs:
  - alu_a = fwd_rs1.
  - alu_b = ex_alu_src ? ex_imm : fwd_rs2.
  - ex_store_data = fwd_rs2 regardless of alu_src.
  - alu_f = stored f, driven to 000 when ex_valid=0.
- Latency: one cycle from ID to the ALU inputs. A bubble costs exactly one cycle.
- Simultaneous events:
  - flush with load_use_stall: the flush wins and no bubble is counted.
  - stall_in with flush: the flush wins.
- Reset mid-stall: all state is cleared immediately; no pending hazard is retained.

Test Plan:
1. Reset then release; drive id_valid=1, add (rs1_data=5, rs2_data=7) → next cycle alu_a=5, alu_b=7, alu_f=000, ex_valid=1.
2. EX rd=x3; next instruction uses rs1=x3; mem_reg_write=1, mem_rd=3, mem_result=0x10, and WB also writes x3=0x20 → alu_a=0x10 (MEM priority). Repeat with mem_rd=0 → alu_a=0x20.
3. EX is a load to x4; ID instruction uses rs2=x4 → load_use_stall=1 for one cycle; next cycle ex_valid=0, bubble_count=1; following cycle the instruction enters with the forwarded value.
4. stall_in=1 for 3 cycles while WB retires x5=0xABCD matching ex_rs1, with WB deasserted afterwards → after release alu_a still 0xABCD.
5. flush asserted together with a load-use hazard → ex_valid=0, ex_reg_write=0, bubble_count unchanged.
6. Forwarding of x0 (mem_rd=0, mem_reg_write=1, ex_rs1=0, stored data 0) → alu_a=0. Also force bubble_count to 0xFFFF, cause another bubble → stays 0xFFFF. Assert reset mid-stall → all outputs 0 asynchronously.

Source files
------------

// File: rtl/id_ex_operand_stage_if.sv
// Bundle between decode, the ID/EX operand stage and the EX/MEM side.
// The master drives the decode bundle and bypass sources; the slave is the operand stage.
interface id_ex_operand_stage_if #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
);
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [RA_W-1:0] id_rs1;
  logic [RA_W-1:0] id_rs2;
  logic            id_use_rs1;
  logic            id_use_rs2;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic            id_alu_src;
  logic [2:0]      id_alu_f;
  logic [RA_W-1:0] id_rd;
  logic            id_reg_write;
  logic            id_mem_read;
  logic            id_mem_write;
  logic            stall_in;
  logic            flush;
  logic            mem_reg_write;
  logic [RA_W-1:0] mem_rd;
  logic [XLEN-1:0] mem_result;
  logic            wb_reg_write;
  logic [RA_W-1:0] wb_rd;
  logic [XLEN-1:0] wb_result;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [2:0]      alu_f;
  logic            ex_valid;
  logic            ex_reg_write;
  logic            ex_mem_read;
  logic            ex_mem_write;
  logic [RA_W-1:0] ex_rd;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_store_data;
  logic            load_use_stall;
  logic [15:0]     bubble_count;

  modport master (
    output id_valid, id_pc, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rs1_data, id_rs2_data, id_imm, id_alu_src, id_alu_f, id_rd,
           id_reg_write, id_mem_read, id_mem_write, stall_in, flush,
           mem_reg_write, mem_rd, mem_result, wb_reg_write, wb_rd, wb_result,
    input  alu_a, alu_b, alu_f, ex_valid, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_rd, ex_pc, ex_store_data, load_use_stall, bubble_count
  );

  modport slave (
    input  id_valid, id_pc, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rs1_data, id_rs2_data, id_imm, id_alu_src, id_alu_f, id_rd,
           id_reg_write, id_mem_read, id_mem_write, stall_in, flush,
           mem_reg_write, mem_rd, mem_result, wb_reg_write, wb_rd, wb_result,
    output alu_a, alu_b, alu_f, ex_valid, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_rd, ex_pc, ex_store_data, load_use_stall, bubble_count
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding, load-use bubble
// insertion and ALU operand selection.
module id_ex_operand_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input logic                clk,
  input logic                reset,
  id_ex_operand_stage_if.slave bus
);

  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [RA_W-1:0] r_rs1;
  logic [RA_W-1:0] r_rs2;
  logic [XLEN-1:0] r_rs1_data;
  logic [XLEN-1:0] r_rs2_data;
  logic [XLEN-1:0] r_imm;
  logic            r_alu_src;
  logic [2:0]      r_alu_f;
  logic [RA_W-1:0] r_rd;
  logic            r_reg_write;
  logic            r_mem_read;
  logic            r_mem_write;
  logic [15:0]     r_bubble_count;

  logic [XLEN-1:0] w_fwd_rs1;
  logic [XLEN-1:0] w_fwd_rs2;
  logic            w_rs1_hit;
  logic            w_rs2_hit;
  logic            w_load_use;

  // MEM is younger than WB, so it wins; x0 is hard-wired and never bypassed.
  always_comb begin
    w_fwd_rs1 = r_rs1_data;
    if (bus.mem_reg_write && (bus.mem_rd != '0) && (bus.mem_rd == r_rs1))
      w_fwd_rs1 = bus.mem_result;
    else if (bus.wb_reg_write && (bus.wb_rd != '0) && (bus.wb_rd == r_rs1))
      w_fwd_rs1 = bus.wb_result;
  end

  always_comb begin
    w_fwd_rs2 = r_rs2_data;
    if (bus.mem_reg_write && (bus.mem_rd != '0) && (bus.mem_rd == r_rs2))
      w_fwd_rs2 = bus.mem_result;
    else if (bus.wb_reg_write && (bus.wb_rd != '0) && (bus.wb_rd == r_rs2))
      w_fwd_rs2 = bus.wb_result;
  end

  assign w_rs1_hit  = bus.id_use_rs1 && (bus.id_rs1 == r_rd);
  assign w_rs2_hit  = bus.id_use_rs2 && (bus.id_rs2 == r_rd);
  assign w_load_use = !bus.stall_in && r_valid && r_mem_read && (r_rd != '0) &&
                      bus.id_valid && (w_rs1_hit || w_rs2_hit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid        <= 1'b0;
      r_pc           <= '0;
      r_rs1          <= '0;
      r_rs2          <= '0;
      r_rs1_data     <= '0;
      r_rs2_data     <= '0;
      r_imm          <= '0;
      r_alu_src      <= 1'b0;
      r_alu_f        <= 3'b000;
      r_rd           <= '0;
      r_reg_write    <= 1'b0;
      r_mem_read     <= 1'b0;
      r_mem_write    <= 1'b0;
      r_bubble_count <= 16'd0;
    end else if (bus.flush) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end else if (bus.stall_in) begin
      // Refresh operands while held so a producer retiring now is not lost.
      r_rs1_data <= w_fwd_rs1;
      r_rs2_data <= w_fwd_rs2;
    end else if (w_load_use) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      if (r_bubble_count != 16'hFFFF)
        r_bubble_count <= r_bubble_count + 16'd1;
    end else begin
      r_valid     <= bus.id_valid;
      r_pc        <= bus.id_pc;
      r_rs1       <= bus.id_rs1;
      r_rs2       <= bus.id_rs2;
      r_rs1_data  <= bus.id_rs1_data;
      r_rs2_data  <= bus.id_rs2_data;
      r_imm       <= bus.id_imm;
      r_alu_src   <= bus.id_alu_src;
      r_alu_f     <= bus.id_alu_f;
      r_rd        <= bus.id_rd;
      r_reg_write <= bus.id_reg_write && bus.id_valid;
      r_mem_read  <= bus.id_mem_read && bus.id_valid;
      r_mem_write <= bus.id_mem_write && bus.id_valid;
    end
  end

  assign bus.alu_a          = w_fwd_rs1;
  assign bus.alu_b          = r_alu_src ? r_imm : w_fwd_rs2;
  assign bus.alu_f          = r_valid ? r_alu_f : 3'b000;
  assign bus.ex_store_data  = w_fwd_rs2;
  assign bus.ex_valid       = r_valid;
  assign bus.ex_reg_write   = r_reg_write;
  assign bus.ex_mem_read    = r_mem_read;
  assign bus.ex_mem_write   = r_mem_write;
  assign bus.ex_rd          = r_rd;
  assign bus.ex_pc          = r_pc;
  assign bus.load_use_stall = w_load_use;
  assign bus.bubble_count   = r_bubble_count;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: directed hazard scenarios followed
// by randomized traffic compared against an instruction-level model of the EX slot.
module tb_id_ex_operand_stage;
  localparam int XLEN = 32;
  localparam int RA_W = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  id_ex_operand_stage_if #(.XLEN(XLEN), .RA_W(RA_W)) ifc ();

  id_ex_operand_stage #(.XLEN(XLEN), .RA_W(RA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  // The instruction currently sitting in EX, as the rules describe it.
  typedef struct {
    logic        valid;
    logic        known;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic        src;
    logic [2:0]  f;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [15:0] bc;
  } slot_t;

  slot_t       m;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] pcCounter = 32'h1000;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] refOperand(input logic [4:0] rs, input logic [31:0] stored);
    if (ifc.mem_reg_write && ifc.mem_rd != 5'd0 && ifc.mem_rd == rs) return ifc.mem_result;
    if (ifc.wb_reg_write && ifc.wb_rd != 5'd0 && ifc.wb_rd == rs) return ifc.wb_result;
    return stored;
  endfunction

  function automatic logic refLoadUse();
    logic reads;
    reads = (ifc.id_use_rs1 && ifc.id_rs1 == m.rd) || (ifc.id_use_rs2 && ifc.id_rs2 == m.rd);
    return !ifc.stall_in && m.valid && m.mr && (m.rd != 5'd0) && ifc.id_valid && reads;
  endfunction

  task automatic modelReset();
    m = '{default: '0};
    m.known = 1'b1;
  endtask

  task automatic checkAll();
    logic [31:0] a, b;
    a = refOperand(m.rs1, m.d1);
    b = refOperand(m.rs2, m.d2);
    checkOutput("ex_valid", 32'(ifc.ex_valid), 32'(m.valid));
    checkOutput("ex_reg_write", 32'(ifc.ex_reg_write), 32'(m.rw));
    checkOutput("ex_mem_read", 32'(ifc.ex_mem_read), 32'(m.mr));
    checkOutput("ex_mem_write", 32'(ifc.ex_mem_write), 32'(m.mw));
    checkOutput("alu_f", 32'(ifc.alu_f), m.valid ? 32'(m.f) : 32'd0);
    checkOutput("load_use_stall", 32'(ifc.load_use_stall), 32'(refLoadUse()));
    checkOutput("bubble_count", 32'(ifc.bubble_count), 32'(m.bc));
    if (m.known) begin
      checkOutput("alu_a", ifc.alu_a, a);
      checkOutput("alu_b", ifc.alu_b, m.src ? m.imm : b);
      checkOutput("ex_store_data", ifc.ex_store_data, b);
      checkOutput("ex_rd", 32'(ifc.ex_rd), 32'(m.rd));
      checkOutput("ex_pc", ifc.ex_pc, m.pc);
    end
  endtask

  task automatic modelStep();
    logic [31:0] a, b;
    a = refOperand(m.rs1, m.d1);
    b = refOperand(m.rs2, m.d2);
    if (ifc.flush) begin
      m.valid = 0; m.rw = 0; m.mr = 0; m.mw = 0; m.known = 0;
    end else if (ifc.stall_in) begin
      m.d1 = a;
      m.d2 = b;
    end else if (refLoadUse()) begin
      m.valid = 0; m.rw = 0; m.mr = 0; m.mw = 0; m.known = 0;
      if (m.bc < 16'hFFFF) m.bc = m.bc + 16'd1;
    end else begin
      m.valid = ifc.id_valid;
      m.known = 1;
      m.pc = ifc.id_pc;
      m.rs1 = ifc.id_rs1;
      m.rs2 = ifc.id_rs2;
      m.d1 = ifc.id_rs1_data;
      m.d2 = ifc.id_rs2_data;
      m.imm = ifc.id_imm;
      m.src = ifc.id_alu_src;
      m.f = ifc.id_alu_f;
      m.rd = ifc.id_rd;
      m.rw = ifc.id_reg_write & ifc.id_valid;
      m.mr = ifc.id_mem_read & ifc.id_valid;
      m.mw = ifc.id_mem_write & ifc.id_valid;
    end
  endtask

  task automatic applyStimulus();
    #1;
    checkAll();
    modelStep();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic setPipeIdle();
    ifc.stall_in = 0; ifc.flush = 0;
    ifc.mem_reg_write = 0; ifc.mem_rd = 0; ifc.mem_result = 0;
    ifc.wb_reg_write = 0; ifc.wb_rd = 0; ifc.wb_result = 0;
  endtask

  task automatic setInstr(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] imm, input logic src,
                          input logic [2:0] f, input logic [4:0] rd,
                          input logic rw, input logic mr, input logic mw);
    pcCounter = pcCounter + 32'd4;
    ifc.id_valid = v; ifc.id_pc = pcCounter;
    ifc.id_rs1 = rs1; ifc.id_rs2 = rs2; ifc.id_use_rs1 = u1; ifc.id_use_rs2 = u2;
    ifc.id_rs1_data = d1; ifc.id_rs2_data = d2; ifc.id_imm = imm;
    ifc.id_alu_src = src; ifc.id_alu_f = f; ifc.id_rd = rd;
    ifc.id_reg_write = rw; ifc.id_mem_read = mr; ifc.id_mem_write = mw;
  endtask

  task automatic randomInputs();
    setInstr(1'($urandom_range(0, 99) < 85), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             1'($urandom), 1'($urandom), $urandom, $urandom, $urandom, 1'($urandom),
             3'($urandom), 5'($urandom_range(0, 7)), 1'($urandom),
             1'($urandom_range(0, 99) < 40), 1'($urandom_range(0, 99) < 15));
    ifc.stall_in = 1'($urandom_range(0, 99) < 15);
    ifc.flush = 1'($urandom_range(0, 99) < 8);
    ifc.mem_reg_write = 1'($urandom_range(0, 99) < 60);
    ifc.mem_rd = 5'($urandom_range(0, 7));
    ifc.mem_result = $urandom;
    ifc.wb_reg_write = 1'($urandom_range(0, 99) < 60);
    ifc.wb_rd = 5'($urandom_range(0, 7));
    ifc.wb_result = $urandom;
  endtask

  initial begin
    logic [15:0] bcBefore;
    reset = 1'b1;
    setPipeIdle();
    setInstr(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
    modelReset();
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state, then a plain add reaches the ALU one cycle later.
    #1;
    checkOutput("rst_alu_a", ifc.alu_a, 32'd0);
    checkOutput("rst_alu_b", ifc.alu_b, 32'd0);
    checkOutput("rst_bubbles", 32'(ifc.bubble_count), 32'd0);
    setInstr(1, 5'd1, 5'd2, 1, 1, 32'd5, 32'd7, 32'd0, 0, 3'b000, 5'd3, 1, 0, 0);
    applyStimulus();
    #1;
    checkOutput("t1_alu_a", ifc.alu_a, 32'd5);
    checkOutput("t1_alu_b", ifc.alu_b, 32'd7);
    checkOutput("t1_alu_f", 32'(ifc.alu_f), 32'd0);
    checkOutput("t1_ex_valid", 32'(ifc.ex_valid), 32'd1);

    // MEM has priority over WB; with MEM pointing at x0 the WB value is used.
    setInstr(1, 5'd3, 5'd2, 1, 0, 32'h99, 32'h0, 32'h0, 0, 3'b001, 5'd8, 1, 0, 0);
    applyStimulus();
    setInstr(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
    ifc.mem_reg_write = 1; ifc.mem_rd = 5'd3; ifc.mem_result = 32'h10;
    ifc.wb_reg_write = 1; ifc.wb_rd = 5'd3; ifc.wb_result = 32'h20;
    #1;
    checkOutput("t2_mem_prio", ifc.alu_a, 32'h10);
    ifc.mem_rd = 5'd0;
    #1;
    checkOutput("t2_wb_fwd", ifc.alu_a, 32'h20);
    applyStimulus();
    setPipeIdle();

    // Load-use: one bubble, then the consumer enters with the loaded value.
    setInstr(1, 5'd1, 5'd0, 1, 0, 32'h100, 32'h0, 32'h8, 1, 3'b000, 5'd4, 1, 1, 0);
    applyStimulus();
    setInstr(1, 5'd1, 5'd4, 1, 1, 32'h3, 32'h55, 32'h0, 0, 3'b000, 5'd9, 1, 0, 0);
    #1;
    checkOutput("t3_stall", 32'(ifc.load_use_stall), 32'd1);
    applyStimulus();
    checkOutput("t3_bubble_valid", 32'(ifc.ex_valid), 32'd0);
    checkOutput("t3_bubble_count", 32'(ifc.bubble_count), 32'd1);
    ifc.mem_reg_write = 1; ifc.mem_rd = 5'd4; ifc.mem_result = 32'h1234;
    applyStimulus();
    setPipeIdle();
    ifc.wb_reg_write = 1; ifc.wb_rd = 5'd4; ifc.wb_result = 32'h1234;
    #1;
    checkOutput("t3_fwd_b", ifc.alu_b, 32'h1234);
    checkOutput("t3_enter_valid", 32'(ifc.ex_valid), 32'd1);
    setInstr(1, 5'd5, 5'd0, 1, 0, 32'h1111, 32'h0, 32'h0, 0, 3'b010, 5'd6, 1, 0, 0);
    applyStimulus();
    setPipeIdle();

    // Held for three cycles while WB retires x5 in the first one only.
    setInstr(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
    ifc.stall_in = 1;
    ifc.wb_reg_write = 1; ifc.wb_rd = 5'd5; ifc.wb_result = 32'hABCD;
    applyStimulus();
    ifc.wb_reg_write = 0;
    applyStimulus();
    applyStimulus();
    ifc.stall_in = 0;
    #1;
    checkOutput("t4_held_a", ifc.alu_a, 32'hABCD);

    // Flush coinciding with a load-use hazard: no bubble counted.
    setInstr(1, 5'd0, 5'd0, 0, 0, 32'h0, 32'h0, 32'h4, 1, 3'b000, 5'd7, 1, 1, 0);
    applyStimulus();
    setInstr(1, 5'd7, 5'd0, 1, 0, 32'h0, 32'h0, 32'h0, 0, 3'b011, 5'd10, 1, 0, 0);
    ifc.flush = 1;
    bcBefore = m.bc;
    applyStimulus();
    ifc.flush = 0;
    checkOutput("t5_valid", 32'(ifc.ex_valid), 32'd0);
    checkOutput("t5_reg_write", 32'(ifc.ex_reg_write), 32'd0);
    checkOutput("t5_bubbles", 32'(ifc.bubble_count), 32'(bcBefore));

    // x0 is never forwarded.
    setInstr(1, 5'd0, 5'd0, 1, 0, 32'h0, 32'h0, 32'h0, 0, 3'b000, 5'd1, 1, 0, 0);
    applyStimulus();
    ifc.mem_reg_write = 1; ifc.mem_rd = 5'd0; ifc.mem_result = 32'hDEAD;
    ifc.wb_reg_write = 1; ifc.wb_rd = 5'd0; ifc.wb_result = 32'hBEEF;
    #1;
    checkOutput("t6_x0", ifc.alu_a, 32'd0);
    setPipeIdle();

    // Bubble counter saturates at 0xFFFF.
    force dut.r_bubble_count = 16'hFFFF;
    m.bc = 16'hFFFF;
    setInstr(1, 5'd0, 5'd0, 0, 0, 32'h0, 32'h0, 32'h0, 1, 3'b000, 5'd4, 1, 1, 0);
    applyStimulus();
    setInstr(1, 5'd4, 5'd0, 1, 0, 32'h0, 32'h0, 32'h0, 0, 3'b000, 5'd2, 1, 0, 0);
    applyStimulus();
    release dut.r_bubble_count;
    setInstr(1, 5'd0, 5'd0, 0, 0, 32'h0, 32'h0, 32'h0, 1, 3'b000, 5'd4, 1, 1, 0);
    applyStimulus();
    setInstr(1, 5'd4, 5'd0, 1, 0, 32'h0, 32'h0, 32'h0, 0, 3'b000, 5'd2, 1, 0, 0);
    applyStimulus();
    checkOutput("t6_saturate", 32'(ifc.bubble_count), 32'hFFFF);

    // Reset asserted in the middle of a hold clears everything without a clock edge.
    ifc.stall_in = 1;
    setInstr(1, 5'd1, 5'd2, 1, 1, 32'h77, 32'h88, 32'h0, 0, 3'b101, 5'd3, 1, 0, 0);
    applyStimulus();
    #2;
    reset = 1'b1;
    #1;
    modelReset();
    checkOutput("rst_mid_valid", 32'(ifc.ex_valid), 32'd0);
    checkOutput("rst_mid_alu_a", ifc.alu_a, 32'd0);
    checkOutput("rst_mid_alu_b", ifc.alu_b, 32'd0);
    checkOutput("rst_mid_alu_f", 32'(ifc.alu_f), 32'd0);
    checkOutput("rst_mid_bubbles", 32'(ifc.bubble_count), 32'd0);
    checkOutput("rst_mid_stall", 32'(ifc.load_use_stall), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    setPipeIdle();

    for (int i = 0; i < 600; i++) begin
      randomInputs();
      applyStimulus();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
